// File: rtl/vdcm_ecg_pkg.sv
// Shared constants, FSM state encoding and bitsReq helpers for the ECG encoder.
package vdcm_ecg_pkg;
  localparam int SAMPLE_W    = 9;
  localparam int MAX_SAMPLES = 7;
  localparam int WORD_W      = 32;
  localparam int ACC_W       = 64;
  localparam int MAG_W       = 8;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_HDR   = 3'd1,
    S_SAMP  = 3'd2,
    S_SIGN  = 3'd3,
    S_FLUSH = 3'd4
  } state_t;

  typedef struct packed {
    logic [7:0] code;
    logic [3:0] len;
  } prefix_t;

  // Prefix is (bitsReq-1) ones then a zero, right-aligned: value 2^bitsReq - 2.
  function automatic prefix_t prefix_of(input logic [3:0] bits_req);
    prefix_t    r;
    logic [8:0] one_hot;
    one_hot = 9'd1 << bits_req;
    r.code  = 8'(one_hot - 9'd2);
    r.len   = bits_req;
    return r;
  endfunction

  function automatic logic [3:0] bit_len(input logic [7:0] v);
    logic [3:0] l;
    l = 4'd0;
    for (int i = 0; i < 8; i++) begin
      if (v[i]) l = 4'(i + 1);
    end
    return l;
  endfunction
endpackage

// File: rtl/ecg_bits_req.sv
// Combinational front end: saturates the used samples, derives bitsReq, skip,
// the nonzero/negative masks and the total coded length of the group.
module ecg_bits_req
  import vdcm_ecg_pkg::*;
(
  input  logic                            sign_mag,
  input  logic [2:0]                      num_sample,
  input  logic [SAMPLE_W*MAX_SAMPLES-1:0] coeff,
  output logic [MAG_W*MAX_SAMPLES-1:0]    codes,
  output logic [MAX_SAMPLES-1:0]          nz_mask,
  output logic [MAX_SAMPLES-1:0]          neg_mask,
  output logic [3:0]                      bits_req,
  output logic                            skip,
  output logic [6:0]                      total_bits
);
  always_comb begin
    logic [8:0]        u;
    logic signed [8:0] s;
    logic [8:0]        a;
    logic [7:0]        code;
    logic [7:0]        span;
    logic [7:0]        max_span;
    logic [2:0]        nz_cnt;
    logic [3:0]        bl;
    codes    = '0;
    nz_mask  = '0;
    neg_mask = '0;
    max_span = '0;
    nz_cnt   = '0;
    u = '0; s = '0; a = '0; code = '0; span = '0;
    for (int i = 0; i < MAX_SAMPLES; i++) begin
      if (3'(i) < num_sample) begin
        u = coeff[SAMPLE_W*i +: SAMPLE_W];
        s = $signed(u);
        if (sign_mag) begin
          a    = u[8] ? (~u + 9'd1) : u;
          code = a[8] ? 8'hFF : a[7:0];
          span = code;
        end else begin
          if (s < $signed(9'h180))    code = 8'h80;
          else if (s > $signed(9'h07F)) code = 8'h7F;
          else                        code = u[7:0];
          // Bits needed for a signed value are those of its non-negative twin, plus the sign.
          span = code[7] ? ~code : code;
        end
        codes[MAG_W*i +: MAG_W] = code;
        nz_mask[i]  = (u != 9'd0);
        neg_mask[i] = u[8];
        if (u != 9'd0) nz_cnt = nz_cnt + 3'd1;
        if (span > max_span) max_span = span;
      end
    end
    bl = bit_len(max_span);
    if (sign_mag) bits_req = (bl == 4'd0) ? 4'd1 : bl;
    else          bits_req = bl + 4'd1;
    skip = (nz_mask == '0);
    if (skip) total_bits = 7'd1;
    else      total_bits = 7'd1 + {3'b0, bits_req} + 7'(num_sample) * {3'b0, bits_req}
                           + (sign_mag ? {4'b0, nz_cnt} : 7'd0);
  end
endmodule

// File: rtl/ecg_encoder.sv
// ECG encoder: serialises skip flag, bitsReq prefix, sample suffixes and sign bits
// into an MSB-first 64-bit accumulator that is drained as 32-bit words.
module ecg_encoder
  import vdcm_ecg_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        in_sign_mag,
  input  logic [2:0]  in_num_sample,
  input  logic [62:0] in_coeff,
  input  logic        flush,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data,
  output logic        out_last,
  output logic        group_done,
  output logic [7:0]  group_bits,
  output logic        flush_done,
  output logic [2:0]  dbg_state
);
  // Both ports: a transfer happens on the rising edge where valid & ready are high;
  // valid never depends on ready, and data is stable while valid is high and unaccepted.
  state_t                         state;
  logic [MAG_W*MAX_SAMPLES-1:0]   codes_r, br_codes;
  logic [MAX_SAMPLES-1:0]         nz_r, neg_r, br_nz, br_neg;
  logic [3:0]                     breq_r, br_breq;
  logic                           skip_r, sm_r, br_skip;
  logic [2:0]                     num_r, idx;
  logic [6:0]                     total_r, br_total;
  logic [ACC_W-1:0]               acc, acc_base, acc_next;
  logic [6:0]                     fill, fill_base, fill_next, shamt;
  logic                           push_en, push_fire, can_push, pop;
  logic [8:0]                     push_data;
  logic [3:0]                     push_len;
  logic                           last_samp, has_sign;
  prefix_t                        pfx;

  ecg_bits_req u_bits_req (
    .sign_mag   (in_sign_mag),
    .num_sample (in_num_sample),
    .coeff      (in_coeff),
    .codes      (br_codes),
    .nz_mask    (br_nz),
    .neg_mask   (br_neg),
    .bits_req   (br_breq),
    .skip       (br_skip),
    .total_bits (br_total)
  );

  assign pfx       = prefix_of(breq_r);
  assign last_samp = (idx == (num_r - 3'd1));
  assign has_sign  = sm_r & (nz_r != '0);

  always_comb begin
    logic [7:0] code;
    logic [7:0] mask8;
    logic [6:0] sign_bits;
    logic [2:0] sign_cnt;
    code      = codes_r[{idx, 3'b000} +: MAG_W];
    mask8     = 8'((9'd1 << breq_r) - 9'd1);
    sign_bits = '0;
    sign_cnt  = '0;
    for (int i = 0; i < MAX_SAMPLES; i++) begin
      if (nz_r[i]) begin
        sign_bits = {sign_bits[5:0], neg_r[i]};
        sign_cnt  = sign_cnt + 3'd1;
      end
    end
    push_en   = 1'b0;
    push_data = '0;
    push_len  = '0;
    case (state)
      S_HDR: begin
        push_en = 1'b1;
        if (skip_r) begin
          push_data = 9'd1;
          push_len  = 4'd1;
        end else begin
          push_data = {1'b0, pfx.code};
          push_len  = pfx.len + 4'd1;
        end
      end
      S_SAMP: begin
        push_en   = 1'b1;
        push_data = {1'b0, code & mask8};
        push_len  = breq_r;
      end
      S_SIGN: begin
        push_en   = 1'b1;
        push_data = {2'b0, sign_bits};
        push_len  = {1'b0, sign_cnt};
      end
      default: ;
    endcase
  end

  // Push admission uses the pre-pop fill so a simultaneous pop never enables a push.
  assign can_push  = ({1'b0, fill} + {4'b0, push_len}) <= 8'd64;
  assign push_fire = push_en & can_push;
  assign out_valid = (fill >= 7'd32) | ((state == S_FLUSH) & (fill != 7'd0));
  assign pop       = out_valid & out_ready;
  assign out_data  = acc[ACC_W-1 -: WORD_W];

  always_comb begin
    fill_base = pop ? ((fill >= 7'd32) ? fill - 7'd32 : 7'd0) : fill;
    acc_base  = pop ? {acc[ACC_W-WORD_W-1:0], {WORD_W{1'b0}}} : acc;
    shamt     = 7'd64 - fill_base - {3'b0, push_len};
    acc_next  = push_fire ? (acc_base | ({55'b0, push_data} << shamt)) : acc_base;
    fill_next = push_fire ? (fill_base + {3'b0, push_len}) : fill_base;
  end

  // Group and flush indications are tied to the push/pop cycle itself, so they are decoded from state.
  assign group_done = push_fire & (((state == S_HDR) & skip_r) |
                                   ((state == S_SAMP) & last_samp & ~has_sign) |
                                   (state == S_SIGN));
  assign group_bits = group_done ? {1'b0, total_r} : 8'd0;
  assign out_last   = (state == S_FLUSH) & (fill != 7'd0) & (fill < 7'd32);
  assign flush_done = (state == S_FLUSH) & ((fill == 7'd0) | (pop & (fill < 7'd32)));
  assign in_ready   = (state == S_IDLE) & ~flush;
  assign dbg_state  = state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      acc     <= '0;
      fill    <= '0;
      codes_r <= '0;
      nz_r    <= '0;
      neg_r   <= '0;
      breq_r  <= 4'd1;
      skip_r  <= 1'b0;
      sm_r    <= 1'b0;
      num_r   <= '0;
      idx     <= '0;
      total_r <= '0;
    end else begin
      acc  <= acc_next;
      fill <= fill_next;
      case (state)
        S_IDLE: begin
          if (flush) begin
            state <= S_FLUSH;
          end else if (in_valid) begin
            codes_r <= br_codes;
            nz_r    <= br_nz;
            neg_r   <= br_neg;
            breq_r  <= br_breq;
            skip_r  <= br_skip;
            sm_r    <= in_sign_mag;
            num_r   <= in_num_sample;
            total_r <= br_total;
            state   <= S_HDR;
          end
        end
        S_HDR: begin
          if (push_fire) begin
            idx   <= '0;
            state <= skip_r ? S_IDLE : S_SAMP;
          end
        end
        S_SAMP: begin
          if (push_fire) begin
            if (last_samp) state <= has_sign ? S_SIGN : S_IDLE;
            else           idx   <= idx + 3'd1;
          end
        end
        S_SIGN:  if (push_fire) state <= S_IDLE;
        S_FLUSH: if (flush_done) state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_ecg_encoder.sv
// Directed bench for ecg_encoder with a bit-queue reference model of the ECG bitstream.
module tb_ecg_encoder;
  import vdcm_ecg_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_sign_mag = 1'b0;
  logic [2:0]  in_num_sample = 3'd1;
  logic [62:0] in_coeff = '0;
  logic        flush = 1'b0;
  logic        out_ready = 1'b1;
  logic        in_ready, out_valid, out_last, group_done, flush_done;
  logic [31:0] out_data;
  logic [7:0]  group_bits;
  logic [2:0]  dbg_state;

  ecg_encoder dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_sign_mag(in_sign_mag), .in_num_sample(in_num_sample), .in_coeff(in_coeff),
    .flush(flush), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_last(out_last), .group_done(group_done), .group_bits(group_bits),
    .flush_done(flush_done), .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  int cyc = 0;
  initial forever begin @(posedge clk); cyc++; end

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic expire(input string name);
    n_cmp++;
    n_err++;
    $display("FAIL %s: wait bound expired (t=%0t)", name, $time);
  endtask

  // ---------------- reference model ----------------
  bit          bq[$];
  logic [31:0] exp_q[$];
  bit          exp_last_q[$];
  int          exp_grp_q[$];
  int          vec[7];
  logic [31:0] last_word = '0;
  bit          last_word_last = 1'b0;
  int          last_grp = 0;

  task automatic put_bits(input int val, input int len);
    logic [31:0] w;
    for (int k = len - 1; k >= 0; k--) bq.push_back(val[k]);
    while (bq.size() >= 32) begin
      w = '0;
      for (int k = 0; k < 32; k++) w[31-k] = bq.pop_front();
      exp_q.push_back(w);
      exp_last_q.push_back(1'b0);
    end
  endtask

  task automatic model_group(input bit sm, input int n);
    int v[7];
    int b, nzc, total, mx, lim;
    bit ok, all_zero;
    all_zero = 1'b1;
    mx = 0;
    nzc = 0;
    for (int i = 0; i < n; i++) begin
      v[i] = vec[i];
      if (sm) begin
        if (v[i] > 255) v[i] = 255;
        if (v[i] < -255) v[i] = -255;
      end else begin
        if (v[i] > 127) v[i] = 127;
        if (v[i] < -128) v[i] = -128;
      end
      if (v[i] != 0) begin all_zero = 1'b0; nzc++; end
      if (sm && ((v[i] < 0 ? -v[i] : v[i]) > mx)) mx = (v[i] < 0) ? -v[i] : v[i];
    end
    if (all_zero) begin
      put_bits(1, 1);
      total = 1;
    end else begin
      b = 1;
      if (sm) begin
        while ((1 << b) <= mx) b++;
      end else begin
        ok = 1'b0;
        while (!ok) begin
          ok = 1'b1;
          lim = 1 << (b - 1);
          for (int i = 0; i < n; i++) if (v[i] < -lim || v[i] > lim - 1) ok = 1'b0;
          if (!ok) b++;
        end
      end
      put_bits(0, 1);
      for (int k = 0; k < b - 1; k++) put_bits(1, 1);
      put_bits(0, 1);
      for (int i = 0; i < n; i++) put_bits(sm ? (v[i] < 0 ? -v[i] : v[i]) : (v[i] & ((1 << b) - 1)), b);
      if (sm) for (int i = 0; i < n; i++) if (v[i] != 0) put_bits(v[i] < 0 ? 1 : 0, 1);
      total = 1 + b + n * b + (sm ? nzc : 0);
    end
    exp_grp_q.push_back(total);
  endtask

  task automatic model_flush();
    logic [31:0] w;
    if (bq.size() > 0) begin
      w = '0;
      for (int k = 0; bq.size() > 0; k++) w[31-k] = bq.pop_front();
      exp_q.push_back(w);
      exp_last_q.push_back(1'b1);
    end
  endtask

  task automatic model_reset();
    bq.delete();
    exp_q.delete();
    exp_last_q.delete();
    exp_grp_q.delete();
  endtask

  // ---------------- driver tasks (called and returning at posedge+1) ----------------
  bit rand_ready = 1'b0;
  int hs_cyc = 0;

  initial forever begin
    @(posedge clk); #1;
    out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  task automatic set_vec(input int a0, input int a1, input int a2, input int a3,
                         input int a4, input int a5, input int a6);
    vec[0] = a0; vec[1] = a1; vec[2] = a2; vec[3] = a3;
    vec[4] = a4; vec[5] = a5; vec[6] = a6;
  endtask

  task automatic send_group(input bit sm, input int n);
    int t;
    in_sign_mag   = sm;
    in_num_sample = 3'(n);
    for (int i = 0; i < 7; i++) in_coeff[9*i +: 9] = 9'(vec[i]);
    in_valid = 1'b1;
    t = 0;
    @(negedge clk);
    while (!in_ready && t < 1000) begin t++; @(negedge clk); end
    if (!in_ready) expire("handshake");
    else begin
      hs_cyc = cyc;
      model_group(sm, n);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("in_ready_busy", in_ready, 0);
  endtask

  task automatic do_flush();
    int t;
    model_flush();
    flush = 1'b1;
    t = 0;
    @(negedge clk);
    while (!flush_done && t < 2000) begin t++; @(negedge clk); end
    if (!flush_done) expire("flush_done");
    @(posedge clk); #1;
    flush = 1'b0;
    check("exp_q_drained", 64'(exp_q.size()), 0);
  endtask

  // ---------------- scoreboard compare process ----------------
  initial forever begin
    logic [31:0] ew;
    bit          el;
    int          eg;
    @(negedge clk);
    if (rst_n) begin
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          n_cmp++; n_err++;
          $display("FAIL out_data: unexpected word %h, none required", out_data);
        end else begin
          ew = exp_q.pop_front();
          el = exp_last_q.pop_front();
          check("out_data", out_data, ew);
          check("out_last", out_last, el);
          last_word      = out_data;
          last_word_last = out_last;
        end
      end
      if (group_done) begin
        if (exp_grp_q.size() == 0) begin
          n_cmp++; n_err++;
          $display("FAIL group_done: unexpected pulse, group_bits %0d", group_bits);
        end else begin
          eg = exp_grp_q.pop_front();
          check("group_bits", group_bits, 64'(eg));
          last_grp = int'(group_bits);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    n_err++;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $fatal(1, "watchdog");
  end

  task automatic check_reset_outputs(input string tag);
    check({tag, "_out_valid"}, out_valid, 0);
    check({tag, "_out_data"}, out_data, 0);
    check({tag, "_out_last"}, out_last, 0);
    check({tag, "_group_done"}, group_done, 0);
    check({tag, "_group_bits"}, group_bits, 0);
    check({tag, "_flush_done"}, flush_done, 0);
    check({tag, "_state"}, dbg_state, S_IDLE);
  endtask

  // ---------------- directed sequence ----------------
  int hs_a;
  initial begin
    #12;
    check_reset_outputs("rst");
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("in_ready_after_rst", in_ready, 1);

    // All-zero sign-magnitude group; unused lanes carry junk that must be ignored.
    set_vec(0, 0, 0, 0, 5, -7, 9);
    send_group(1'b1, 4);
    do_flush();
    check("t1_word", last_word, 32'h80000000);
    check("t1_last", last_word_last, 1);
    check("t1_bits", last_grp, 1);

    set_vec(3, -1, 0, 2, 0, 0, 0);
    send_group(1'b1, 4);
    do_flush();
    check("t2_word", last_word, 32'h5A480000);
    check("t2_bits", last_grp, 14);

    set_vec(-4, 3, 100, 0, 0, 0, 0);
    send_group(1'b0, 2);
    do_flush();
    check("t3_word", last_word, 32'h68C00000);
    check("t3_bits", last_grp, 10);

    set_vec(-256, 0, 0, 0, 0, 0, 0);
    send_group(1'b0, 1);
    do_flush();
    check("t4_word", last_word, 32'h7F400000);
    check("t4_bits", last_grp, 17);

    // Back-to-back throughput with out_ready held high.
    set_vec(0, 0, 0, 0, 0, 0, 0);
    send_group(1'b1, 3); hs_a = hs_cyc;
    send_group(1'b1, 3);
    check("tput_skip", 64'(hs_cyc - hs_a), 2);
    set_vec(3, -1, 0, 2, 0, 0, 0);
    send_group(1'b1, 4); hs_a = hs_cyc;
    send_group(1'b1, 4);
    check("tput_sm", 64'(hs_cyc - hs_a), 7);
    set_vec(-4, 3, 0, 0, 0, 0, 0);
    send_group(1'b0, 2); hs_a = hs_cyc;
    send_group(1'b0, 2);
    check("tput_2c", 64'(hs_cyc - hs_a), 4);
    set_vec(255, 127, -1, 0, 0, 0, 0);
    send_group(1'b0, 3);
    set_vec(1, 0, -1, 0, 0, 0, 0);
    send_group(1'b1, 3);
    do_flush();

    // Maximum-length groups against a randomly stalling consumer.
    rand_ready = 1'b1;
    for (int g = 0; g < 5; g++) begin
      for (int i = 0; i < 7; i++) vec[i] = ((i + g) % 2 == 1) ? -255 : 255;
      if (g == 2) vec[3] = -256;
      send_group(1'b1, 7);
    end
    do_flush();
    rand_ready = 1'b0;
    @(posedge clk); #1;

    // Reset pulse while the encoder is in SAMP.
    set_vec(255, 255, 255, 255, 255, 255, 255);
    send_group(1'b1, 7);
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midrst");
    model_reset();
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("in_ready_after_midrst", in_ready, 1);
    set_vec(3, -1, 0, 2, 0, 0, 0);
    send_group(1'b1, 4);
    do_flush();
    check("t7_word", last_word, 32'h5A480000);
    check("t7_bits", last_grp, 14);

    repeat (4) @(posedge clk);
    check("grp_q_drained", 64'(exp_grp_q.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
